// File: rtl/input_quant_packer.sv
`default_nettype none
// ============================================================================
// Module   : input_quant_packer
// Brief    : Quantises signed raw features against per-feature thresholds and
//            packs NUM_FEATURES codes into one vector for LUT layer 0.
//            Optional framing check on s_last enabled by macro LAST_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module input_quant_packer #(
    parameter int NUM_FEATURES = 16,
    parameter int IN_WIDTH     = 16,
    parameter int BITS         = 2,
    parameter logic [NUM_FEATURES*(2**BITS-1)*IN_WIDTH-1:0] THRESH = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [IN_WIDTH-1:0]          s_data,
`ifdef LAST_CHECK_EN
    input  logic                         s_last,
    output logic                         err,
`endif
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_FEATURES*BITS-1:0] m_data
);

    localparam int T     = 2**BITS - 1;
    localparam int IDX_W = $clog2(NUM_FEATURES);
    localparam int VEC_W = NUM_FEATURES * BITS;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [VEC_W-1:0] r_buf;
    logic [VEC_W-1:0] r_m_data;
    logic             r_m_valid;

    logic [IN_WIDTH-1:0] w_thr;
    logic [BITS-1:0]     w_code;
    logic [VEC_W-1:0]    w_next_buf;
    logic                w_accept;
    logic                w_at_last;
    logic                w_frame_ok;

    // Thermometer count: thresholds ascend, so the count of passed ones is the code
    always_comb begin
        w_thr  = '0;
        w_code = '0;
        for (int k = 0; k < T; k++) begin
            w_thr = THRESH[(int'(r_idx) * T + k) * IN_WIDTH +: IN_WIDTH];
            if ($signed(s_data) >= $signed(w_thr)) begin
                w_code = w_code + BITS'(1);
            end
        end
    end

    always_comb begin
        w_next_buf = r_buf;
        w_next_buf[int'(r_idx) * BITS +: BITS] = w_code;
    end

    assign s_ready   = (r_state == S_FILL);
    assign w_accept  = s_valid && s_ready;
    assign w_at_last = (r_idx == c_LAST_IDX);

`ifdef LAST_CHECK_EN
    logic r_err;
    assign w_frame_ok = (s_last == w_at_last);
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_frame_ok) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FILL;
            r_idx     <= '0;
            r_buf     <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_buf <= w_next_buf;
                        if (!w_frame_ok) begin
                            // Misframed vector is dropped; restart at slot 0
                            r_idx <= '0;
                        end else if (w_at_last) begin
                            r_m_data  <= w_next_buf;
                            r_m_valid <= 1'b1;
                            r_idx     <= '0;
                            r_state   <= S_HOLD;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= S_FILL;
                    end
                end
            endcase
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_input_quant_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_quant_packer
// Brief    : Directed bench with a per-cycle reference model for the packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_quant_packer;

    localparam int N = 4;
    localparam int W = 16;
    localparam int B = 2;
    localparam logic [N*3*W-1:0] c_THRESH = {N{ {16'h0064, 16'h0000, 16'hFF9C} }};

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           m_ready = 1'b1;
    logic [W-1:0]   s_data = '0;
    logic           s_ready;
    logic           m_valid;
    logic [N*B-1:0] m_data;
`ifdef LAST_CHECK_EN
    logic           err;
`endif

    int total = 0;
    int bad   = 0;

    // model state
    int         mcnt = 0;
    int         mcodes[N];
    bit         mhold = 1'b0;
    logic [7:0] mout = '0;
    bit         merr = 1'b0;

    input_quant_packer #(
        .NUM_FEATURES(N),
        .IN_WIDTH    (W),
        .BITS        (B),
        .THRESH      (c_THRESH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
`ifdef LAST_CHECK_EN
        .s_last (s_last),
        .err    (err),
`endif
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data)
    );

    always #5 clk = ~clk;

    function automatic int quant(input int x);
        int thr[3];
        int c;
        thr[0] = -100; thr[1] = 0; thr[2] = 100;
        c = 0;
        for (int k = 0; k < 3; k++) if (x >= thr[k]) c++;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect codes, emit a vector on the N-th good beat, hold until taken
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mcnt = 0; mhold = 1'b0; mout = '0; merr = 1'b0;
        end else if (mhold) begin
            if (m_ready) mhold = 1'b0;
        end else if (s_valid) begin
            mcodes[mcnt] = quant(int'($signed(s_data)));
`ifdef LAST_CHECK_EN
            if (s_last != (mcnt == N-1)) begin
                merr = 1'b1;
                mcnt = 0;
            end else
`endif
            if (mcnt == N-1) begin
                for (int i = 0; i < N; i++) mout[i*B +: B] = mcodes[i][B-1:0];
                mhold = 1'b1;
                mcnt  = 0;
            end else begin
                mcnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("m_valid", {31'd0, m_valid}, {31'd0, mhold});
        check("s_ready", {31'd0, s_ready}, {31'd0, !mhold});
        check("m_data", {24'd0, m_data}, {24'd0, mout});
`ifdef LAST_CHECK_EN
        check("err", {31'd0, err}, {31'd0, merr});
`endif
    end

    task automatic send(input int v, input bit last);
        int n;
        s_valid = 1'b1;
        s_data  = W'(v);
        s_last  = last;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); send(d, 1'b1);
    endtask

    task automatic wait_vec(input string name, input logic [7:0] exp);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, {31'd0, m_valid}, 32'd1);
        check({name, "_data"}, {24'd0, m_data}, {24'd0, exp});
        check({name, "_sready"}, {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        // model pinning: boundary codes
        check("q_m101", quant(-101), 0);
        check("q_m100", quant(-100), 1);
        check("q_0", quant(0), 2);
        check("q_100", quant(100), 3);
        check("q_max", quant(32767), 3);

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);

        // back-to-back vector, taken immediately
        m_ready = 1'b1;
        send4(-200, -50, 50, 200);
        wait_vec("t1", 8'hE4);
        @(posedge clk); #1;

        // boundaries: codes 1,2,3,3
        send4(-100, 0, 100, 32767);
        wait_vec("t2", 8'hF9);
        @(posedge clk); #1;

        // backpressure for 5 cycles
        m_ready = 1'b0;
        send4(-200, -50, 50, 200);
        wait_vec("t3", 8'hE4);
        repeat (5) @(posedge clk);
        #1;
        check("t3_held_data", {24'd0, m_data}, 32'h0000_00E4);
        check("t3_held_valid", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        send4(-200, -200, -200, -200);
        wait_vec("t3b", 8'h00);
        @(posedge clk); #1;

        // reset discards a partial vector
        send(200, 1'b0); send(200, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", {31'd0, m_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send4(200, 200, 200, 200);
        wait_vec("t4", 8'hFF);
        @(posedge clk); #1;

        // gapped input
        for (int i = 0; i < N; i++) begin
            send(-200, i == N-1);
            if (i < N-1) begin
                @(posedge clk); #1;
            end
        end
        wait_vec("t5", 8'h00);
        @(posedge clk); #1;

`ifdef LAST_CHECK_EN
        send(-200, 1'b0); send(-200, 1'b1);
        check("t6_err", {31'd0, err}, 32'd1);
        check("t6_no_valid", {31'd0, m_valid}, 32'd0);
        send4(-200, -50, 50, 200);
        wait_vec("t6", 8'hE4);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
